// File: rtl/wb_arb_pkg.sv
// Shared defaults and types for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

    // Round-robin priority pointer: which requester wins the next tie.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A reservation from the issue stage sets a bit, the register file write
// clears it, and a source operand whose bit is set stalls issue.
module wb_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic                alloc_valid_i,
    input  logic [ADDR_W-1:0]   alloc_addr_i,
    input  logic [ADDR_W-1:0]   chk_rs_i,
    input  logic [ADDR_W-1:0]   chk_rt_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                stall_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy mask: clear first so a same-edge reservation of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (we_i) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (alloc_valid_i && (alloc_addr_i != '0)) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy register; reset drops every reservation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o  = busy_q;
    assign stall_o = busy_q[chk_rs_i] | busy_q[chk_rt_i];

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between the pipeline writeback (A) and a
// multi-cycle unit (B). Round-robin on ties, registered write outputs.
// Optional scoreboard enabled by defining WB_ARB_SCOREBOARD_EN; without it
// busy_o/stall_o are tied low and the alloc/check inputs are ignored.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                a_valid_i,
    output logic                a_ready_o,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W-1:0]   a_data_i,
    input  logic                b_valid_i,
    output logic                b_ready_o,
    input  logic [ADDR_W-1:0]   b_addr_i,
    input  logic [DATA_W-1:0]   b_data_i,
    output logic                RegWrite_o,
    output logic [ADDR_W-1:0]   RDaddr_o,
    output logic [DATA_W-1:0]   RDdata_o,
    input  logic                alloc_valid_i,
    input  logic [ADDR_W-1:0]   alloc_addr_i,
    input  logic [ADDR_W-1:0]   chk_rs_i,
    input  logic [ADDR_W-1:0]   chk_rt_i,
    output logic                stall_o,
    output logic [NUM_REGS-1:0] busy_o
);

    req_id_e             ptr_q, ptr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                grant_a, grant_b;

    // Grant selection and next output-stage values; the grantee loses priority.
    always_comb begin
        grant_a = a_valid_i && (!b_valid_i || (ptr_q == REQ_A));
        grant_b = b_valid_i && !grant_a;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (grant_a) begin
            ptr_d  = REQ_B;
            addr_d = a_addr_i;
            data_d = a_data_i;
            we_d   = (a_addr_i != '0);
        end else if (grant_b) begin
            ptr_d  = REQ_A;
            addr_d = b_addr_i;
            data_d = b_data_i;
            we_d   = (b_addr_i != '0);
        end
    end

    // Priority pointer and registered write port; reset kills any in-flight write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q  <= REQ_A;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign a_ready_o  = grant_a;
    assign b_ready_o  = grant_b;
    assign RegWrite_o = we_q;
    assign RDaddr_o   = addr_q;
    assign RDdata_o   = data_q;

`ifdef WB_ARB_SCOREBOARD_EN
    wb_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .we_i          (we_q),
        .wr_addr_i     (addr_q),
        .alloc_valid_i (alloc_valid_i),
        .alloc_addr_i  (alloc_addr_i),
        .chk_rs_i      (chk_rs_i),
        .chk_rt_i      (chk_rt_i),
        .busy_o        (busy_o),
        .stall_o       (stall_o)
    );
`else
    logic unused_sb;
    assign unused_sb = ^{alloc_valid_i, alloc_addr_i, chk_rs_i, chk_rt_i};
    assign busy_o    = '0;
    assign stall_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter. Scoreboard scenarios run when
// WB_ARB_SCOREBOARD_EN is defined; otherwise stall_o/busy_o must stay 0.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        a_valid_i, b_valid_i;
    logic        a_ready_o, b_ready_o;
    logic [4:0]  a_addr_i, b_addr_i;
    logic [31:0] a_data_i, b_data_i;
    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic        alloc_valid_i;
    logic [4:0]  alloc_addr_i, chk_rs_i, chk_rt_i;
    logic        stall_o;
    logic [31:0] busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .a_valid_i     (a_valid_i),
        .a_ready_o     (a_ready_o),
        .a_addr_i      (a_addr_i),
        .a_data_i      (a_data_i),
        .b_valid_i     (b_valid_i),
        .b_ready_o     (b_ready_o),
        .b_addr_i      (b_addr_i),
        .b_data_i      (b_data_i),
        .RegWrite_o    (RegWrite_o),
        .RDaddr_o      (RDaddr_o),
        .RDdata_o      (RDdata_o),
        .alloc_valid_i (alloc_valid_i),
        .alloc_addr_i  (alloc_addr_i),
        .chk_rs_i      (chk_rs_i),
        .chk_rt_i      (chk_rt_i),
        .stall_o       (stall_o),
        .busy_o        (busy_o)
    );

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid_i = 0; b_valid_i = 0;
        a_addr_i = 0; b_addr_i = 0; a_data_i = 0; b_data_i = 0;
        alloc_valid_i = 0; alloc_addr_i = 0; chk_rs_i = 0; chk_rt_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_i = 1;
        tick();
        rst_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        idle_inputs();
        #3;
        total++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, a_ready_o, b_ready_o, stall_o, busy_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h busy=%h, want all 0",
                     RegWrite_o, RDaddr_o, RDdata_o, busy_o);
        end
        tick();
        rst_i = 0;
        // Load a write, then reset mid-cycle while it is on the port.
        a_valid_i = 1; a_addr_i = 10; a_data_i = 32'h1234_5678;
        alloc_valid_i = 1; alloc_addr_i = 12;
        tick();
        idle_inputs();
        total++;
        if (RegWrite_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_preload_we: got %b want 1", RegWrite_o);
        end
        #3 rst_i = 1;
        #1;
        total++;
        if ({RegWrite_o, RDaddr_o, RDdata_o, stall_o, busy_o} !== '0) begin
            bad++;
            $display("FAIL reset_midop: got we=%b addr=%0d data=%h busy=%h, want all 0",
                     RegWrite_o, RDaddr_o, RDdata_o, busy_o);
        end
        tick();
        rst_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (RegWrite_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_we cycle %0d: got %b want 0", i, RegWrite_o);
            end
        end
    endtask

    task automatic test_single();
        a_valid_i = 1; a_addr_i = 5; a_data_i = 32'hDEADBEEF;
        #1;
        total++;
        if ({a_ready_o, b_ready_o} !== 2'b10) begin
            bad++;
            $display("FAIL single_ready: got a=%b b=%b want a=1 b=0", a_ready_o, b_ready_o);
        end
        tick();
        a_valid_i = 0;
        total++;
        if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL single_write: got we=%b addr=%0d data=%h want 1/5/deadbeef",
                     RegWrite_o, RDaddr_o, RDdata_o);
        end
        tick();
        total++;
        if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL single_after: got we=%b addr=%0d data=%h want 0/5/deadbeef (held)",
                     RegWrite_o, RDaddr_o, RDdata_o);
        end
    endtask

    task automatic test_contention();
        logic [4:0] exp_addr;
        do_reset();
        a_valid_i = 1; a_addr_i = 3; a_data_i = 32'hA3;
        b_valid_i = 1; b_addr_i = 4; b_data_i = 32'hB4;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({a_ready_o, b_ready_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL contention_grant %0d: got a=%b b=%b want %s", i,
                         a_ready_o, b_ready_o, (i % 2 == 0) ? "A" : "B");
            end
            tick();
            exp_addr = (i % 2 == 0) ? 5'd3 : 5'd4;
            total++;
            if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b1, exp_addr, (i % 2 == 0) ? 32'hA3 : 32'hB4}) begin
                bad++;
                $display("FAIL contention_out %0d: got we=%b addr=%0d data=%h want we=1 addr=%0d",
                         i, RegWrite_o, RDaddr_o, RDdata_o, exp_addr);
            end
        end
        idle_inputs();
        tick();
        total++;
        if (RegWrite_o !== 1'b0) begin
            bad++;
            $display("FAIL contention_end: got we=%b want 0", RegWrite_o);
        end
    endtask

    task automatic test_back_to_back();
        a_valid_i = 1; a_addr_i = 6; a_data_i = 32'h1111;
        tick();
        a_data_i = 32'h2222;
        total++;
        if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b1, 5'd6, 32'h1111}) begin
            bad++;
            $display("FAIL b2b_first: got we=%b addr=%0d data=%h want 1/6/1111",
                     RegWrite_o, RDaddr_o, RDdata_o);
        end
        tick();
        a_valid_i = 0;
        total++;
        if ({RegWrite_o, RDaddr_o, RDdata_o} !== {1'b1, 5'd6, 32'h2222}) begin
            bad++;
            $display("FAIL b2b_second: got we=%b addr=%0d data=%h want 1/6/2222",
                     RegWrite_o, RDaddr_o, RDdata_o);
        end
        tick();
    endtask

    task automatic test_reg0();
        b_valid_i = 1; b_addr_i = 0; b_data_i = 32'h55;
        #1;
        total++;
        if ({a_ready_o, b_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL reg0_ready: got a=%b b=%b want a=0 b=1", a_ready_o, b_ready_o);
        end
        tick();
        b_valid_i = 0;
        total++;
        if (RegWrite_o !== 1'b0) begin
            bad++;
            $display("FAIL reg0_we: got %b want 0", RegWrite_o);
        end
    endtask

    // Last grant was B (reg0), so pointer is A: lone A wins, then a tie goes to B.
    task automatic test_pointer();
        a_valid_i = 1; a_addr_i = 1; a_data_i = 32'h1;
        #1;
        total++;
        if ({a_ready_o, b_ready_o} !== 2'b10) begin
            bad++;
            $display("FAIL ptr_lone_a: got a=%b b=%b want A", a_ready_o, b_ready_o);
        end
        tick();
        a_addr_i = 2; a_data_i = 32'h2;
        b_valid_i = 1; b_addr_i = 8; b_data_i = 32'h8;
        #1;
        total++;
        if ({a_ready_o, b_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL ptr_tie: got a=%b b=%b want B", a_ready_o, b_ready_o);
        end
        tick();
        idle_inputs();
        total++;
        if ({RegWrite_o, RDaddr_o} !== {1'b1, 5'd8}) begin
            bad++;
            $display("FAIL ptr_tie_out: got we=%b addr=%0d want 1/8", RegWrite_o, RDaddr_o);
        end
        tick();
    endtask

`ifdef WB_ARB_SCOREBOARD_EN
    task automatic test_scoreboard();
        do_reset();
        alloc_valid_i = 1; alloc_addr_i = 7; chk_rs_i = 7;
        #1;
        total++;
        if (stall_o !== 1'b0) begin
            bad++;
            $display("FAIL sb_cycle0: got stall=%b want 0", stall_o);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            alloc_valid_i = 0;
            b_valid_i = (c == 4);
            b_addr_i = 7; b_data_i = 32'h77;
            if (c == 3) begin
                chk_rs_i = 0; chk_rt_i = 7;
            end
            #1;
            total++;
            if (stall_o !== (c < 6)) begin
                bad++;
                $display("FAIL sb_stall cycle %0d: got %b want %b", c, stall_o, c < 6);
            end
            if (c == 5) begin
                total++;
                if ({RegWrite_o, RDaddr_o} !== {1'b1, 5'd7}) begin
                    bad++;
                    $display("FAIL sb_write: got we=%b addr=%0d want 1/7", RegWrite_o, RDaddr_o);
                end
            end
        end
        idle_inputs();
        // Set wins over clear on the same register and edge; alloc of 0 is ignored.
        alloc_valid_i = 1; alloc_addr_i = 9;
        tick();
        alloc_valid_i = 0;
        a_valid_i = 1; a_addr_i = 9; a_data_i = 32'h99;
        tick();
        a_valid_i = 0;
        alloc_valid_i = 1; alloc_addr_i = 9;
        total++;
        if ({RegWrite_o, RDaddr_o} !== {1'b1, 5'd9}) begin
            bad++;
            $display("FAIL setwins_write: got we=%b addr=%0d want 1/9", RegWrite_o, RDaddr_o);
        end
        tick();
        alloc_addr_i = 0;
        tick();
        alloc_valid_i = 0;
        total++;
        if (busy_o !== 32'h0000_0200) begin
            bad++;
            $display("FAIL setwins_busy: got %h want 00000200", busy_o);
        end
    endtask
`else
    task automatic test_no_scoreboard();
        do_reset();
        alloc_valid_i = 1; alloc_addr_i = 7; chk_rs_i = 7; chk_rt_i = 7;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({stall_o, busy_o} !== '0) begin
                bad++;
                $display("FAIL nosb cycle %0d: got stall=%b busy=%h want 0", c, stall_o, busy_o);
            end
        end
        idle_inputs();
    endtask
`endif

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_reg0();
        test_pointer();
`ifdef WB_ARB_SCOREBOARD_EN
        test_scoreboard();
`else
        test_no_scoreboard();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the register file's single write port between the main pipeline writeback (requester A) and a multi-cycle unit (requester B). It sits between the writeback sources and the register file, and drives its write-enable, write-address and write-data inputs from a registered output stage. An optional scoreboard tracks destination registers that have been reserved but not yet written, and raises an issue-stage stall when a source operand is still pending.

## Interface
- NUM_REGS, 32, number of architectural registers
- ADDR_W, 5, register address width
- DATA_W, 32, write data width

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- a_valid_i  in  1  requester A has a write
- a_ready_o  out  1  requester A write accepted this cycle
- a_addr_i  in  ADDR_W  requester A destination
- a_data_i  in  DATA_W  requester A data
- b_valid_i  in  1  requester B has a write
- b_ready_o  out  1  requester B write accepted this cycle
- b_addr_i  in  ADDR_W  requester B destination
- b_data_i  in  DATA_W  requester B data
- RegWrite_o  out  1  register file write enable
- RDaddr_o  out  ADDR_W  register file write address
- RDdata_o  out  DATA_W  register file write data
- alloc_valid_i  in  1  issue stage reserves a destination
- alloc_addr_i  in  ADDR_W  reserved destination
- chk_rs_i  in  ADDR_W  issue-stage source operand 1
- chk_rt_i  in  ADDR_W  issue-stage source operand 2
- stall_o  out  1  a source operand is pending
- busy_o  out  NUM_REGS  pending-write bitmask

## Operation
- Handshake: a transfer occurs when valid and ready are both high at a clock edge. Requesters hold valid, addr and data stable until ready is seen. Ready is combinational from valid. At most one ready is high per cycle.
- Arbitration: round-robin with a 1-bit priority pointer.
  - Reset value of the pointer: A.
  - When both requesters are valid, the pointer holder is granted.
  - After any grant, the pointer moves to the non-granted requester.
  - A lone valid requester is always granted.
- Output stage: on a transfer, RDaddr_o/RDdata_o load the granted addr/data and RegWrite_o is set to 1. With no transfer, RegWrite_o is 0 and addr/data hold their values.
- Address 0: a write to address 0 is accepted (ready asserted), but RegWrite_o stays 0.
- Scoreboard:
  - alloc_valid_i with a nonzero address sets busy[alloc_addr_i].
  - busy[RDaddr_o] clears at the clock edge that ends a cycle with RegWrite_o=1.
  - If a set and a clear target the same register at the same edge, the set wins.
  - busy[0] is always 0.
  - stall_o = busy[chk_rs_i] | busy[chk_rt_i], combinational.

## Timing
- Reset values: all outputs 0, busy 0, pointer A. Reset mid-operation drops any in-flight write (RegWrite_o forced to 0) and clears every busy bit.
- Handshake at edge E0 -> RegWrite_o=1 during cycle E0..E1 -> the register file writes at E1 -> busy clears at E1 -> stall_o falls in the cycle after E1.
- Throughput: one write per cycle. Under contention, A and B alternate every cycle.
- Back-to-back writes to the same register: RegWrite_o stays high, and the second data appears one cycle after the first.

## Configuration
- WB_ARB_SCOREBOARD_EN defined: the scoreboard is built as described above.
- Undefined: no scoreboard state. busy_o and stall_o are tied 0, and alloc_valid_i, alloc_addr_i, chk_rs_i and chk_rt_i are ignored. Arbitration and the output stage are unchanged.

## Structure
- Package wb_arb_pkg holds NUM_REGS, ADDR_W and DATA_W defaults, plus the requester-id enum REQ_A/REQ_B used for the priority pointer.
- Sub-module wb_scoreboard holds the busy register, set/clear logic and stall lookup. It is instantiated only under WB_ARB_SCOREBOARD_EN.

## Test plan
- Reset then idle: rst_i pulse mid-cycle -> all outputs 0 immediately. After release with no valid inputs, RegWrite_o stays 0.
- Single write: a_valid_i=1, a_addr_i=5, a_data_i=0xDEADBEEF -> a_ready_o=1 that cycle. Next cycle RegWrite_o=1, RDaddr_o=5, RDdata_o=0xDEADBEEF. The cycle after, RegWrite_o=0.
- Contention: A (addr 3) and B (addr 4) both held valid for 4 cycles from reset -> grants in order A, B, A, B. RegWrite_o stays 1 with RDaddr_o sequence 3, 4, 3, 4.
- Register 0: b_valid_i=1, b_addr_i=0 -> b_ready_o=1. RegWrite_o stays 0 next cycle.
- Scoreboard: alloc 7 at cycle 0, then chk_rs_i=7 -> stall_o=1 from cycle 1. B writes 7 with handshake at cycle 4 -> RegWrite_o=1 in cycle 5 -> stall_o=0 from cycle 6.
- Set wins: alloc 9 in the same cycle RegWrite_o=1 with RDaddr_o=9 -> busy[9] remains 1 afterward. Without WB_ARB_SCOREBOARD_EN -> stall_o is 0 throughout.
